// File: rtl/mips_multicycle_core_pkg.sv
// Shared opcode/funct constants, FSM state and datapath select types
// for the multi-cycle MIPS32 subset core.
package mips_multicycle_core_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

    typedef enum logic [1:0] {
        PC_NPC,
        PC_BRANCH,
        PC_JUMP
    } pc_sel_t;

    typedef struct packed {
        logic    ir_we;
        logic    ab_we;
        logic    alu_we;
        logic    alu_src_imm;
        alu_op_t alu_op;
        logic    pc_we;
        pc_sel_t pc_sel;
        logic    mdr_we;
        logic    rf_we;
        logic    rf_dst_rd;
        logic    rf_from_mdr;
        logic    addr_data;
        logic    retire;
    } ctrl_t;

    function automatic logic [31:0] alu_calc(input alu_op_t op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] r;
        case (op)
            ALU_SUB: r = a - b;
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_SLT: r = {31'b0, ($signed(a) < $signed(b))};
            default: r = a + b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mips_multicycle_core_if.sv
// Unified memory port shared by instruction fetch and data access;
// req/ready handshake lets memory insert any number of wait states.
interface mips_multicycle_core_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mips_multicycle_core_ctrl.sv
// Sequencing FSM and instruction decode; drives datapath enables/selects.
//   state     | meaning
//   ST_FETCH  | request IR at PC, wait for ready
//   ST_DECODE | latch A, B, sign-extended immediate
//   ST_EXEC   | ALU op, or resolve branch/jump and retire
//   ST_MEM    | data access at ALUOut, wait for ready
//   ST_WB     | register writeback, PC<=NPC, retire
//   ST_HALT   | stopped until reset
module mips_multicycle_core_ctrl
    import mips_multicycle_core_pkg::*;
#(
    parameter int HALT_ON_ILLEGAL = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    input  logic       i_a_eq_b,
    input  logic       i_mem_ready,
    output logic       o_mem_req,
    output logic       o_mem_we,
    output logic       o_halted,
    output ctrl_t      o_ctrl
);
    state_t  r_state;
    state_t  w_next;
    logic    r_run;
    logic    w_r_legal;
    alu_op_t w_r_op;

    // r_run keeps the bus quiet for the cycle(s) following a reset edge
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= ST_FETCH;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_run   <= 1'b1;
        end
    end

    always_comb begin
        w_r_legal = 1'b1;
        w_r_op    = ALU_ADD;
        case (i_funct)
            FN_ADD:  w_r_op = ALU_ADD;
            FN_SUB:  w_r_op = ALU_SUB;
            FN_AND:  w_r_op = ALU_AND;
            FN_OR:   w_r_op = ALU_OR;
            FN_SLT:  w_r_op = ALU_SLT;
            default: w_r_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_next    = r_state;
        o_ctrl    = '0;
        o_mem_req = 1'b0;
        o_mem_we  = 1'b0;
        o_halted  = (r_state == ST_HALT);
        case (r_state)
            ST_FETCH: begin
                o_mem_req = r_run;
                if (r_run && i_mem_ready) begin
                    o_ctrl.ir_we = 1'b1;
                    w_next       = ST_DECODE;
                end
            end
            ST_DECODE: begin
                o_ctrl.ab_we = 1'b1;
                w_next       = ST_EXEC;
            end
            ST_EXEC: begin
                if (i_op == OP_RTYPE && w_r_legal) begin
                    o_ctrl.alu_we = 1'b1;
                    o_ctrl.alu_op = w_r_op;
                    w_next        = ST_WB;
                end else if (i_op == OP_ADDI || i_op == OP_LW || i_op == OP_SW) begin
                    o_ctrl.alu_we      = 1'b1;
                    o_ctrl.alu_src_imm = 1'b1;
                    w_next             = (i_op == OP_ADDI) ? ST_WB : ST_MEM;
                end else if (i_op == OP_BEQ || i_op == OP_BNE) begin
                    o_ctrl.pc_we  = 1'b1;
                    o_ctrl.pc_sel = ((i_op == OP_BEQ) == i_a_eq_b) ? PC_BRANCH : PC_NPC;
                    o_ctrl.retire = 1'b1;
                    w_next        = ST_FETCH;
                end else if (i_op == OP_J) begin
                    o_ctrl.pc_we  = 1'b1;
                    o_ctrl.pc_sel = PC_JUMP;
                    o_ctrl.retire = 1'b1;
                    w_next        = ST_FETCH;
                end else if (HALT_ON_ILLEGAL != 0) begin
                    w_next = ST_HALT;
                end else begin
                    o_ctrl.pc_we  = 1'b1;
                    o_ctrl.retire = 1'b1;
                    w_next        = ST_FETCH;
                end
            end
            ST_MEM: begin
                o_mem_req        = r_run;
                o_mem_we         = (i_op == OP_SW);
                o_ctrl.addr_data = 1'b1;
                if (r_run && i_mem_ready) begin
                    if (i_op == OP_SW) begin
                        o_ctrl.pc_we  = 1'b1;
                        o_ctrl.retire = 1'b1;
                        w_next        = ST_FETCH;
                    end else begin
                        o_ctrl.mdr_we = 1'b1;
                        w_next        = ST_WB;
                    end
                end
            end
            ST_WB: begin
                o_ctrl.rf_we       = 1'b1;
                o_ctrl.rf_dst_rd   = (i_op == OP_RTYPE);
                o_ctrl.rf_from_mdr = (i_op == OP_LW);
                o_ctrl.pc_we       = 1'b1;
                o_ctrl.retire      = 1'b1;
                w_next             = ST_FETCH;
            end
            ST_HALT: w_next = ST_HALT;
            default: w_next = ST_FETCH;
        endcase
    end
endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS32 subset core: datapath registers, register file and ALU,
// sequenced by mips_multicycle_core_ctrl over one shared memory port.
module mips_multicycle_core
    import mips_multicycle_core_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          ADDR_W          = 32,
    parameter int          HALT_ON_ILLEGAL = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    mips_multicycle_core_if.master bus,
    output logic                   o_retire,
    output logic                   o_halted,
    output logic [31:0]            o_pc_dbg
);
    logic [31:0] r_pc, r_npc, r_ir, r_a, r_b, r_sext, r_alu_out, r_mdr;
    logic [31:0] r_gpr [0:31];
    logic        r_retire;

    ctrl_t       w_ctrl;
    logic        w_mem_req, w_mem_we;
    logic [4:0]  w_rs, w_rt, w_rd, w_wb_idx;
    logic [31:0] w_rs_val, w_rt_val, w_alu_b, w_alu_res, w_pc_next, w_wb_data, w_addr_full;

    assign w_rs = r_ir[25:21];
    assign w_rt = r_ir[20:16];
    assign w_rd = r_ir[15:11];

    // $0 is never written, but force the read to zero regardless
    assign w_rs_val  = (w_rs == 5'd0) ? 32'h0 : r_gpr[w_rs];
    assign w_rt_val  = (w_rt == 5'd0) ? 32'h0 : r_gpr[w_rt];
    assign w_alu_b   = w_ctrl.alu_src_imm ? r_sext : r_b;
    assign w_alu_res = alu_calc(w_ctrl.alu_op, r_a, w_alu_b);
    assign w_wb_idx  = w_ctrl.rf_dst_rd ? w_rd : w_rt;
    assign w_wb_data = w_ctrl.rf_from_mdr ? r_mdr : r_alu_out;

    always_comb begin
        w_pc_next = r_npc;
        case (w_ctrl.pc_sel)
            PC_BRANCH: w_pc_next = r_npc + {r_sext[29:0], 2'b00};
            PC_JUMP:   w_pc_next = {r_npc[31:28], r_ir[25:0], 2'b00};
            default:   w_pc_next = r_npc;
        endcase
    end

    mips_multicycle_core_ctrl #(
        .HALT_ON_ILLEGAL(HALT_ON_ILLEGAL)
    ) u_ctrl (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_op        (r_ir[31:26]),
        .i_funct     (r_ir[5:0]),
        .i_a_eq_b    (r_a == r_b),
        .i_mem_ready (bus.mem_ready),
        .o_mem_req   (w_mem_req),
        .o_mem_we    (w_mem_we),
        .o_halted    (o_halted),
        .o_ctrl      (w_ctrl)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_pc      <= RESET_PC;
            r_npc     <= 32'h0;
            r_ir      <= 32'h0;
            r_a       <= 32'h0;
            r_b       <= 32'h0;
            r_sext    <= 32'h0;
            r_alu_out <= 32'h0;
            r_mdr     <= 32'h0;
            r_retire  <= 1'b0;
            for (int i = 0; i < 32; i++) r_gpr[i] <= 32'h0;
        end else begin
            r_retire <= w_ctrl.retire;
            if (w_ctrl.ir_we) begin
                r_ir  <= bus.mem_rdata;
                r_npc <= r_pc + 32'd4;
            end
            if (w_ctrl.ab_we) begin
                r_a    <= w_rs_val;
                r_b    <= w_rt_val;
                r_sext <= {{16{r_ir[15]}}, r_ir[15:0]};
            end
            if (w_ctrl.alu_we) r_alu_out <= w_alu_res;
            if (w_ctrl.mdr_we) r_mdr <= bus.mem_rdata;
            if (w_ctrl.pc_we) r_pc <= w_pc_next;
            if (w_ctrl.rf_we && w_wb_idx != 5'd0) r_gpr[w_wb_idx] <= w_wb_data;
        end
    end

    // Word aligned: bits [1:0] are always driven low
    assign w_addr_full   = w_ctrl.addr_data ? r_alu_out : r_pc;
    assign bus.mem_req   = w_mem_req;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = w_addr_full[ADDR_W-1:0] & ~{{(ADDR_W-2){1'b0}}, 2'b11};
    assign bus.mem_wdata = r_b;
    assign o_retire      = r_retire;
    assign o_pc_dbg      = r_pc;
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: small programs in a wait-state
// memory model, results observed through the bus, retire timing and stores.
`timescale 1ns/1ps
module tb_mips_multicycle_core;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        retire, halted;
    logic [31:0] pc_dbg;

    always #5 clk = ~clk;

    mips_multicycle_core_if #(.ADDR_W(32)) bus ();

    mips_multicycle_core #(
        .RESET_PC        (32'h0000_0000),
        .ADDR_W          (32),
        .HALT_ON_ILLEGAL (1)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .bus      (bus),
        .o_retire (retire),
        .o_halted (halted),
        .o_pc_dbg (pc_dbg)
    );

    // memory model: 256 words, programmable wait states, access/write/retire logs
    logic [31:0] mem [0:255];
    int          waits = 0;
    int          wcnt = 0;
    logic        ld_we = 1'b0, ld_clr = 1'b0;
    logic [7:0]  ld_idx = 8'h0;
    logic [31:0] ld_data = 32'h0;
    int          cyc = 0, acc_n = 0, wr_n = 0, ret_n = 0, wait_cyc = 0, unstable = 0;
    logic [31:0] acc_addr [0:511];
    logic [31:0] wr_addr  [0:511];
    logic [31:0] wr_data  [0:511];
    int          ret_cyc  [0:511];
    logic        hold = 1'b0, h_we = 1'b0;
    logic [31:0] h_addr = 32'h0, h_wdata = 32'h0;

    always_comb bus.mem_ready = bus.mem_req && (wcnt == waits);
    assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (ld_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        end else if (ld_we) begin
            mem[ld_idx] <= ld_data;
        end
        if (bus.mem_req && bus.mem_ready) begin
            if (acc_n < 512) acc_addr[acc_n] = bus.mem_addr;
            acc_n = acc_n + 1;
            if (bus.mem_we) begin
                mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
                if (wr_n < 512) begin
                    wr_addr[wr_n] = bus.mem_addr;
                    wr_data[wr_n] = bus.mem_wdata;
                end
                wr_n = wr_n + 1;
            end
            wcnt <= 0;
            hold = 1'b0;
        end else if (bus.mem_req) begin
            wait_cyc = wait_cyc + 1;
            if (hold && (bus.mem_addr !== h_addr || bus.mem_we !== h_we || bus.mem_wdata !== h_wdata))
                unstable = unstable + 1;
            hold    = 1'b1;
            h_addr  = bus.mem_addr;
            h_we    = bus.mem_we;
            h_wdata = bus.mem_wdata;
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
            hold = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (retire) begin
            if (ret_n < 512) ret_cyc[ret_n] = cyc;
            ret_n = ret_n + 1;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic load(input int idx, input logic [31:0] data);
        ld_we   = 1'b1;
        ld_idx  = idx[7:0];
        ld_data = data;
        tick(1);
        ld_we   = 1'b0;
    endtask

    task automatic clear_mem();
        ld_clr = 1'b1;
        tick(1);
        ld_clr = 1'b0;
    endtask

    task automatic wait_halt(input int budget, input string tag);
        int k;
        k = 0;
        while (!halted && k < budget) begin
            tick(1);
            k++;
        end
        chk(tag, {31'b0, halted}, 32'h1);
    endtask

    int acc_b, ret_b, wr_b, wait_b, unst_b, cnt;

    initial begin
        // ---- T1: ALU / ADDI program, zero wait states
        rst   = 1'b0;
        waits = 0;
        tick(1);
        clear_mem();
        load(0,  32'h20010005);  // addi $1,$0,5
        load(1,  32'h2002FFFD);  // addi $2,$0,-3
        load(2,  32'h00221820);  // add  $3,$1,$2
        load(3,  32'h00222022);  // sub  $4,$1,$2
        load(4,  32'h00222824);  // and  $5,$1,$2
        load(5,  32'h00223025);  // or   $6,$1,$2
        load(6,  32'h0041382A);  // slt  $7,$2,$1
        load(7,  32'h0022402A);  // slt  $8,$1,$2
        load(8,  32'h20000007);  // addi $0,$0,7
        load(9,  32'h2009FFFF);  // addi $9,$0,-1
        load(10, 32'h212A0001);  // addi $10,$9,1
        load(11, 32'hAC030080);  // sw $3,0x80
        load(12, 32'hAC040084);
        load(13, 32'hAC050088);
        load(14, 32'hAC06008C);
        load(15, 32'hAC070090);
        load(16, 32'hAC080094);
        load(17, 32'hAC000098);  // sw $0,0x98
        load(18, 32'hAC0A009C);  // sw $10,0x9C
        load(19, 32'hFC000000);  // illegal
        for (int i = 32; i < 40; i++) load(i, 32'hA5A5A5A5);
        chk("rst_mem_req", {31'b0, bus.mem_req}, 32'h0);
        chk("rst_mem_we",  {31'b0, bus.mem_we}, 32'h0);
        chk("rst_retire",  {31'b0, retire}, 32'h0);
        chk("rst_halted",  {31'b0, halted}, 32'h0);
        chk("rst_pc",      pc_dbg, 32'h0);
        acc_b = acc_n; ret_b = ret_n; wr_b = wr_n;
        rst = 1'b1;
        wait_halt(300, "t1_halt");
        chk("t1_first_fetch", acc_addr[acc_b], 32'h0);
        chk("t1_retires", ret_n - ret_b, 32'd19);
        chk("t1_addi_lat", ret_cyc[ret_b+1] - ret_cyc[ret_b], 32'd4);
        chk("t1_add_lat",  ret_cyc[ret_b+2] - ret_cyc[ret_b+1], 32'd4);
        chk("t1_sw_lat",   ret_cyc[ret_b+11] - ret_cyc[ret_b+10], 32'd4);
        chk("t1_writes", wr_n - wr_b, 32'd8);
        chk("t1_add", mem[32], 32'h00000002);
        chk("t1_sub", mem[33], 32'h00000008);
        chk("t1_and", mem[34], 32'h00000005);
        chk("t1_or",  mem[35], 32'hFFFFFFFD);
        chk("t1_slt_true",  mem[36], 32'h00000001);
        chk("t1_slt_false", mem[37], 32'h00000000);
        chk("t1_r0_zero",   mem[38], 32'h00000000);
        chk("t1_wrap",      mem[39], 32'h00000000);
        chk("t1_halt_req",  {31'b0, bus.mem_req}, 32'h0);

        // ---- T2: SW/LW with 2 wait states on every access, entered via j 0x40
        rst = 1'b0;
        tick(1);
        clear_mem();
        waits = 2;
        load(0,  32'h08000040);  // j 0x40 -> 0x100
        load(64, 32'h8C010080);  // lw $1,0x80($0)
        load(65, 32'hAC010008);  // sw $1,8($0)
        load(66, 32'h8C040008);  // lw $4,8($0)
        load(67, 32'hAC040084);  // sw $4,0x84($0)
        load(68, 32'hFC000000);
        load(32, 32'hDEADBEEF);
        acc_b = acc_n; ret_b = ret_n; wr_b = wr_n; wait_b = wait_cyc; unst_b = unstable;
        rst = 1'b1;
        wait_halt(300, "t2_halt");
        chk("t2_fetch0", acc_addr[acc_b], 32'h0);
        chk("t2_jump_target", acc_addr[acc_b+1], 32'h100);
        chk("t2_sw_addr", wr_addr[wr_b], 32'h8);
        chk("t2_sw_data", wr_data[wr_b], 32'hDEADBEEF);
        chk("t2_lw_roundtrip", mem[33], 32'hDEADBEEF);
        chk("t2_wait_cycles", wait_cyc - wait_b, 32'd20);
        chk("t2_stable", unstable - unst_b, 32'd0);
        // each of the two accesses adds 2 wait cycles to the base latency
        chk("t2_sw_lat", ret_cyc[ret_b+2] - ret_cyc[ret_b+1], 32'd8);
        chk("t2_lw_lat", ret_cyc[ret_b+3] - ret_cyc[ret_b+2], 32'd9);

        // ---- T3: branches
        rst = 1'b0;
        tick(1);
        clear_mem();
        waits = 0;
        load(0,  32'h08000008);  // j 0x20
        load(8,  32'h14210004);  // 0x20 bne $1,$1,+4 (not taken)
        load(9,  32'h20010001);  // 0x24 addi $1,$0,1
        load(10, 32'h14200002);  // 0x28 bne $1,$0,+2 -> 0x34
        load(11, 32'hFC000000);
        load(12, 32'hFC000000);
        load(13, 32'h08000004);  // 0x34 j 0x10
        load(4,  32'h1021FFFF);  // 0x10 beq $1,$1,-1
        acc_b = acc_n; ret_b = ret_n;
        rst = 1'b1;
        tick(45);
        chk("t3_f1_bne_pc",   acc_addr[acc_b+1], 32'h20);
        chk("t3_bne_nt",      acc_addr[acc_b+2], 32'h24);
        chk("t3_f3",          acc_addr[acc_b+3], 32'h28);
        chk("t3_bne_taken",   acc_addr[acc_b+4], 32'h34);
        chk("t3_j_to_beq",    acc_addr[acc_b+5], 32'h10);
        chk("t3_beq_self",    acc_addr[acc_b+6], 32'h10);
        chk("t3_beq_self2",   acc_addr[acc_b+7], 32'h10);
        chk("t3_bne_nt_lat",  ret_cyc[ret_b+1] - ret_cyc[ret_b], 32'd3);
        chk("t3_bne_t_lat",   ret_cyc[ret_b+3] - ret_cyc[ret_b+2], 32'd3);
        chk("t3_not_halted",  {31'b0, halted}, 32'h0);

        // ---- T4: illegal opcode halts, reset recovers
        rst = 1'b0;
        tick(1);
        clear_mem();
        load(0, 32'hFC000000);
        ret_b = ret_n;
        rst = 1'b1;
        wait_halt(20, "t4_halt");
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (bus.mem_req) cnt++;
        end
        chk("t4_req_quiet", cnt, 32'd0);
        chk("t4_no_retire", ret_n - ret_b, 32'd0);
        chk("t4_pc_held", pc_dbg, 32'h0);
        rst = 1'b0;
        tick(1);
        chk("t4_rst_halted", {31'b0, halted}, 32'h0);
        chk("t4_rst_req", {31'b0, bus.mem_req}, 32'h0);
        rst = 1'b1;
        tick(1);
        chk("t4_refetch_req", {31'b0, bus.mem_req}, 32'h1);
        chk("t4_refetch_addr", bus.mem_addr, 32'h0);

        // ---- T5: reset during an SW data wait
        rst = 1'b0;
        tick(1);
        clear_mem();
        waits = 2;
        load(0, 32'hAC000080);  // sw $0,0x80($0)
        load(32, 32'h12345678);
        rst = 1'b1;
        cnt = 0;
        while (!(bus.mem_req && bus.mem_we) && cnt < 30) begin
            tick(1);
            cnt++;
        end
        chk("t5_reached_mem", {31'b0, bus.mem_req && bus.mem_we}, 32'h1);
        wr_b = wr_n;
        rst = 1'b0;
        tick(1);
        chk("t5_req_dropped", {31'b0, bus.mem_req}, 32'h0);
        chk("t5_pc_reset", pc_dbg, 32'h0);
        chk("t5_no_retire", {31'b0, retire}, 32'h0);
        tick(3);
        chk("t5_no_write", wr_n - wr_b, 32'd0);
        chk("t5_mem_intact", mem[32], 32'h12345678);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
